// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide execute unit.
// Runs one bit per cycle: shift-add multiply, restoring divide. The result is
// registered, and the pipe stalls on busy.
// Ports:
//   clk, rst (synchronous, active-low), flush (kills any in-flight op)
//   req_valid/req_ready, funct3, a, b  : request handshake and operands
//   busy                               : high in CALC and DONE
//   resp_valid, resp_data              : one-cycle result pulse; data holds after
// Optional feature: define MULDIV_FAST_ZERO_EN to skip CALC when b==0 (any op)
// or a==0 (mul ops). The result then arrives one cycle after accept.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] md_q, md_d;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;        // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;        // multiplier -> product low / dividend -> quotient
  logic             neg_q, neg_d;      // negate product or quotient
  logic             neg_r_q, neg_r_d;  // negate remainder (dividend sign)
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;

  logic             accept;
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo, rem, fin;
  logic             unused_div_bit;

  assign req_ready  = (state_q == S_IDLE) & ~flush;
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE) & ~flush;
  // A flushed DONE cycle shows the previous response, not the new result.
  assign resp_data  = resp_valid ? result_q : resp_data_q;
  assign accept     = req_valid & req_ready;

  // The top bit of a non-borrowing difference is always zero.
  assign unused_div_bit = div_diff[WIDTH];

  // Operand signedness and magnitudes for the incoming request.
  always_comb begin
    a_signed = (funct3 == 3'd1) | (funct3 == 3'd2) | (funct3 == 3'd4) | (funct3 == 3'd6);
    b_signed = (funct3 == 3'd1) | (funct3 == 3'd4) | (funct3 == 3'd6);
    a_neg    = a_signed & a[WIDTH-1];
    b_neg    = b_signed & b[WIDTH-1];
    a_mag    = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag    = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // Next-state and datapath iteration.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    md_d        = md_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    neg_d       = neg_q;
    neg_r_d     = neg_r_q;
    div0_d      = div0_q;
    result_d    = result_q;
    resp_data_d = resp_data_q;

    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, md_q};

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_CALC;
          cnt_d   = '0;
          op_d    = funct3;
          md_d    = funct3[2] ? b_mag : a_mag;
          hi_d    = '0;
          lo_d    = funct3[2] ? a_mag : b_mag;
          neg_d   = a_neg ^ b_neg;
          neg_r_d = a_neg;
          div0_d  = (b == '0);
`ifdef MULDIV_FAST_ZERO_EN
          if ((b == '0) || (!funct3[2] && (a == '0))) begin
            state_d  = S_DONE;
            result_d = funct3[2] ? (funct3[1] ? a : '1) : '0;
          end
`endif
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          // Restoring divide: keep the difference only when it did not borrow.
          if (!div_diff[WIDTH+1]) begin
            hi_d = div_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = fin;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (resp_valid) resp_data_d = result_q;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Sign fix-up and result selection from the final iteration's values.
  always_comb begin
    prod = {hi_d, lo_d};
    if (neg_q) prod = ~prod + W2'(1);
    quo = neg_q ? (~lo_d + WIDTH'(1)) : lo_d;
    if (div0_q) quo = '1;
    rem = neg_r_q ? (~hi_d + WIDTH'(1)) : hi_d;
    case (op_q)
      3'd0:              fin = prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:  fin = prod[W2-1:WIDTH];
      3'd4, 3'd5:        fin = quo;
      default:           fin = rem;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      md_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      neg_q       <= 1'b0;
      neg_r_q     <= 1'b0;
      div0_q      <= 1'b0;
      result_q    <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      md_q        <= md_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      neg_q       <= neg_d;
      neg_r_q     <= neg_r_d;
      div0_q      <= div0_d;
      result_q    <= result_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule
